// File: rtl/quotient_bcd_converter.sv
// quotient_bcd_converter: captures a divider result and converts the
// quotient to packed BCD by serial double-dabble, one bit per clock.
module quotient_bcd_converter #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10,
  parameter int RWIDTH = 16
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic [WIDTH-1:0]      div_q,
  input  logic [RWIDTH-1:0]     div_r,
  input  logic                  div_ready,
  input  logic                  out_ack,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [RWIDTH-1:0]     rem_out,
  output logic                  busy,
  output logic                  out_valid,
  output logic                  overrun
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BW = 4 * DIGITS;

  typedef enum logic {
    S_IDLE,
    S_CONV
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                ready_d;
  logic                capture;
  logic                done;
  logic [BW-1:0]       acc;
  logic [BW-1:0]       corr;
  logic [WIDTH-1:0]    sr;
  logic [BW+WIDTH-1:0] cat;
  logic [CW-1:0]       cnt;
  logic [RWIDTH-1:0]   rem_pending;

  assign capture = div_ready & ~ready_d;
  assign done    = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: idle until a capture, convert for WIDTH iterations
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (capture) state_nxt = S_CONV;
      S_CONV: if (done)    state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state == S_CONV);
  end

  // Add-3 correction of every digit >= 5, then one-bit left shift
  always_comb begin
    corr = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5)
        corr[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    cat = {corr, sr} << 1;
  end

  // Datapath: capture, iterate, publish result and handshake flags
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ready_d     <= 1'b0;
      acc         <= '0;
      sr          <= '0;
      cnt         <= '0;
      rem_pending <= '0;
      bcd         <= '0;
      rem_out     <= '0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      ready_d <= div_ready;
      if (state == S_IDLE) begin
        if (capture) begin
          sr          <= div_q;
          acc         <= '0;
          rem_pending <= div_r;
          cnt         <= '0;
          out_valid   <= 1'b0;
        end else if (out_ack) begin
          out_valid <= 1'b0;
        end
      end else begin
        if (capture) overrun <= 1'b1;
        acc <= cat[BW+WIDTH-1:WIDTH];
        sr  <= cat[WIDTH-1:0];
        cnt <= cnt + CW'(1);
        if (done) begin
          bcd       <= cat[BW+WIDTH-1:WIDTH];
          rem_out   <= rem_pending;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_quotient_bcd_converter.sv
// tb_quotient_bcd_converter: directed and random stimulus checked
// against a decimal-arithmetic model of the converter.
module tb_quotient_bcd_converter;

  localparam int WIDTH  = 32;
  localparam int DIGITS = 10;
  localparam int RWIDTH = 16;

  logic                clk;
  logic                clrn;
  logic [WIDTH-1:0]    div_q;
  logic [RWIDTH-1:0]   div_r;
  logic                div_ready;
  logic                out_ack;
  logic [4*DIGITS-1:0] bcd;
  logic [RWIDTH-1:0]   rem_out;
  logic                busy;
  logic                out_valid;
  logic                overrun;

  int n_chk  = 0;
  int n_pass = 0;

  quotient_bcd_converter #(
    .WIDTH (WIDTH),
    .DIGITS(DIGITS),
    .RWIDTH(RWIDTH)
  ) dut (
    .clk      (clk),
    .clrn     (clrn),
    .div_q    (div_q),
    .div_r    (div_r),
    .div_ready(div_ready),
    .out_ack  (out_ack),
    .bcd      (bcd),
    .rem_out  (rem_out),
    .busy     (busy),
    .out_valid(out_valid),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%0h exp=%0h", name, act, exp);
  endtask

  function automatic logic [4*DIGITS-1:0] to_bcd(input logic [WIDTH-1:0] v);
    longint unsigned x;
    logic [4*DIGITS-1:0] r;
    x = 64'(v);
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Behavioural model: a countdown of remaining cycles plus decimal result
  int                  m_cnt;
  logic                m_rd;
  logic                m_valid;
  logic                m_ov;
  logic [WIDTH-1:0]    m_q;
  logic [RWIDTH-1:0]   m_pr;
  logic [4*DIGITS-1:0] m_bcd;
  logic [RWIDTH-1:0]   m_rem;

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      m_cnt = 0; m_rd = 0; m_valid = 0; m_ov = 0;
      m_q = '0; m_pr = '0; m_bcd = '0; m_rem = '0;
    end else begin
      logic cap;
      cap  = div_ready && !m_rd;
      m_rd = div_ready;
      if (m_cnt > 0) begin
        if (cap) m_ov = 1'b1;
        m_cnt--;
        if (m_cnt == 0) begin
          m_bcd   = to_bcd(m_q);
          m_rem   = m_pr;
          m_valid = 1'b1;
        end
      end else if (cap) begin
        m_q = div_q; m_pr = div_r; m_cnt = WIDTH; m_valid = 1'b0;
      end else if (out_ack) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (clrn) begin
      chk("m_bcd", 64'(bcd), 64'(m_bcd));
      chk("m_rem", 64'(rem_out), 64'(m_rem));
      chk("m_busy", 64'(busy), 64'(m_cnt > 0));
      chk("m_valid", 64'(out_valid), 64'(m_valid));
      chk("m_overrun", 64'(overrun), 64'(m_ov));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [WIDTH-1:0] q, input logic [RWIDTH-1:0] r);
    div_q = q;
    div_r = r;
    div_ready = 1'b1;
    tick(1);
    div_ready = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      tick(1);
      n++;
    end
    chk("valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bcd"}, 64'(bcd), 64'd0);
    chk({tag, "_rem"}, 64'(rem_out), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_ovr"}, 64'(overrun), 64'd0);
  endtask

  initial begin
    clrn = 1'b0;
    div_q = '0;
    div_r = '0;
    div_ready = 1'b0;
    out_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    clrn = 1'b1;
    tick(1);

    // Zero quotient, single-cycle ready pulse
    pulse(32'd0, 16'h1234);
    chk("t1_busy", 64'(busy), 64'd1);
    tick(31);
    chk("t1_notyet", 64'(out_valid), 64'd0);
    tick(1);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_bcd", 64'(bcd), 64'h0);
    chk("t1_rem", 64'(rem_out), 64'h1234);

    // Level held for 50 cycles gives one conversion
    div_q = 32'd12345;
    div_r = 16'h00AB;
    div_ready = 1'b1;
    tick(50);
    div_ready = 1'b0;
    tick(1);
    chk("t2_bcd", 64'(bcd), 64'h0000012345);
    chk("t2_rem", 64'(rem_out), 64'h00AB);
    chk("t2_ovr", 64'(overrun), 64'd0);
    chk("t2_busy", 64'(busy), 64'd0);

    // Max quotient, then old value held during the next conversion
    pulse(32'hFFFF_FFFF, 16'h0001);
    tick(33);
    chk("t3_max", 64'(bcd), 64'h4294967295);
    pulse(32'd1000000000, 16'h0002);
    tick(20);
    chk("t3_hold", 64'(bcd), 64'h4294967295);
    chk("t3_hold_v", 64'(out_valid), 64'd0);
    wait_valid();
    chk("t3_1e9", 64'(bcd), 64'h1000000000);

    // Acknowledge, then capture colliding with acknowledge
    out_ack = 1'b1;
    tick(1);
    out_ack = 1'b0;
    chk("t4_ack_v", 64'(out_valid), 64'd0);
    chk("t4_ack_bcd", 64'(bcd), 64'h1000000000);
    pulse(32'd7, 16'h0007);
    wait_valid();
    div_q = 32'd8;
    div_ready = 1'b1;
    out_ack = 1'b1;
    tick(1);
    div_ready = 1'b0;
    out_ack = 1'b0;
    chk("t4_col_v", 64'(out_valid), 64'd0);
    chk("t4_col_busy", 64'(busy), 64'd1);
    wait_valid();
    chk("t4_bcd8", 64'(bcd), 64'h8);

    // Second rising edge mid-conversion flags overrun only
    div_q = 32'd4321;
    div_r = 16'h0042;
    div_ready = 1'b1;
    tick(3);
    div_ready = 1'b0;
    tick(7);
    div_ready = 1'b1;
    tick(10);
    div_ready = 1'b0;
    wait_valid();
    chk("t5_ovr", 64'(overrun), 64'd1);
    chk("t5_bcd", 64'(bcd), 64'h4321);
    tick(40);
    chk("t5_idle", 64'(busy), 64'd0);
    chk("t5_valid", 64'(out_valid), 64'd1);

    // Reset during iteration 15
    pulse(32'd555, 16'h0555);
    tick(14);
    clrn = 1'b0;
    #1;
    chk_zero("t6");
    tick(2);
    clrn = 1'b1;
    tick(1);
    pulse(32'd99, 16'h0099);
    wait_valid();
    chk("t6_bcd99", 64'(bcd), 64'h99);
    chk("t6_rem", 64'(rem_out), 64'h0099);

    // Random transactions with random acknowledges
    for (int t = 0; t < 25; t++) begin
      int h, l, tot, sel;
      sel = $urandom_range(0, 7);
      if (sel == 0)      div_q = '0;
      else if (sel == 1) div_q = '1;
      else               div_q = $urandom;
      div_r = 16'($urandom);
      h = $urandom_range(1, 40);
      l = $urandom_range(1, 5);
      tot = (h + l < 34) ? 34 : h + l;
      for (int c = 0; c < tot; c++) begin
        div_ready = (c < h);
        out_ack = ($urandom_range(0, 3) == 0);
        tick(1);
      end
      div_ready = 1'b0;
      out_ack = 1'b0;
    end
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/quotient_bcd_converter.md
Name: quotient_bcd_converter

Overview:
- Downstream consumer of the restoring divider's result port.
- On each new divider completion (rising edge of the divider's level-type ready), captures quotient and remainder.
- Converts the quotient to packed BCD with a sequential shift-and-add-3 (double-dabble) engine, one bit per clock.
- Presents the decimal result and the latched remainder to display/reporting logic under a valid/ack handshake.

Parameters:
- WIDTH, 32, quotient width in bits.
- DIGITS, 10, BCD digits produced; must be at least ceil(WIDTH*log10(2)).
- RWIDTH, 16, remainder width in bits.

Ports:
- clk  input  1  system clock, rising-edge.
- clrn  input  1  reset; one clock, asynchronous, active-low.
- div_q  input  WIDTH  quotient from divider; stable while div_ready is high.
- div_r  input  RWIDTH  remainder from divider; stable while div_ready is high.
- div_ready  input  1  divider result-ready level; stays high until the divider's next start.
- out_ack  input  1  consumer acknowledge; clears out_valid.
- bcd  output  4*DIGITS  packed BCD of the last completed quotient; digit 0 in bits [3:0].
- rem_out  output  RWIDTH  remainder latched with the same capture as bcd.
- busy  output  1  conversion in progress.
- out_valid  output  1  bcd/rem_out hold a completed, unacknowledged result.
- overrun  output  1  sticky: a new div_ready rising edge arrived while busy.

Behaviour:
- Reset (clrn low, asynchronous) clears:
  - bcd, rem_out, busy, out_valid, overrun, internal accumulator, shift register, counter and ready_d all to 0.
  - Reset mid-conversion aborts the conversion; no partial result is ever shown.
- Edge detect:
  - ready_d is div_ready registered.
  - capture = div_ready & ~ready_d.
  - A level held high for many cycles yields exactly one capture.
- IDLE state (busy=0), on capture at edge E0:
  - shift register <= div_q; accumulator <= 0; rem_pending <= div_r; count <= 0.
  - busy <= 1; out_valid <= 0.
- CONVERT state (busy=1), one iteration per edge:
  - First, every accumulator digit >= 5 gets +3 (4-bit add, no carry between digits).
  - Then {accumulator, shift register} shifts left one bit, MSB of the shift register entering accumulator bit 0.
  - count increments by 1.
  - On the iteration where count == WIDTH-1, the corrected-and-shifted value is written to bcd, and rem_pending is written to rem_out.
  - Same edge: busy <= 0, out_valid <= 1.
- Latency: WIDTH iterations at edges E1..EWIDTH; out_valid is high after edge E(WIDTH) (E32 at defaults), i.e. WIDTH+1 edges after capture.
- bcd and rem_out change only at completion; they stay stable during a conversion and hold the previous result.
- out_valid:
  - Cleared on the edge where out_ack=1, and also on a new capture.
  - Capture and out_ack in the same cycle: capture wins (load, out_valid 0).
  - out_ack while out_valid=0 has no effect.
- Capture while busy:
  - Ignored; the conversion continues unchanged.
  - overrun <= 1; stays set until reset.
- The divider cannot complete faster than WIDTH+1 cycles, so overrun indicates a system fault.
- Counter is $clog2(WIDTH) bits and never wraps within a conversion.

Test Plan:
- Reset, then div_q=0, pulse div_ready high 1 cycle -> busy for 32 cycles, then out_valid=1, bcd=0x0000000000, rem_out=div_r.
- div_q=12345, div_r=0x00AB, div_ready held high 50 cycles -> exactly one conversion; bcd=0x0000012345, rem_out=0x00AB, overrun=0.
- div_q=0xFFFFFFFF -> bcd=0x4294967295; then div_q=1000000000 -> bcd=0x1000000000. Check bcd keeps the old value until the second completion.
- Completed result, out_ack=1 for one cycle -> out_valid 0 next edge; bcd unchanged. New capture in the same cycle as out_ack -> out_valid 0, busy 1.
- div_ready rises at cycle 0, falls at 3, rises again at 10 (mid-conversion) -> overrun=1; first result still correct; no second conversion.
- clrn low at iteration 15 -> all outputs 0 immediately. After release, a fresh capture of div_q=99 -> bcd=0x0000000099.
